// File: rtl/mario_sample_player_mc.sv
// mario_sample_player_mc: multi-channel sample player sharing one sample ROM through
// a time-sliced fetch arbiter, with per-channel volume scaling and a saturating mixer.
module mario_sample_player_mc #(
    parameter int NCH  = 3,
    parameter int AW   = 13,
    parameter int DIVW = 12
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic [DIVW-1:0]   I_DIV,
    input  logic [3:0]        I_VOL,
    input  logic [NCH-1:0]    I_TRIG,
    input  logic [NCH-1:0]    I_STOP,
    input  logic [NCH-1:0]    I_RETRIG_EN,
    input  logic [NCH-1:0]    I_LOOP,
    input  logic [NCH*AW-1:0] I_START,
    input  logic [NCH*AW-1:0] I_LEN,
    output logic [AW-1:0]     O_ROM_ADDR,
    input  logic [15:0]       I_ROM_DATA,
    output logic [NCH-1:0]    O_BUSY,
    output logic [NCH*16-1:0] O_SND,
    output logic [15:0]       O_MIX
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [DIVW-1:0]    r_div_cnt;
    logic [SW-1:0]      r_slot;
    logic               r_phase;
    logic               r_armed;
    logic [NCH-1:0]     r_trig_q;
    logic [NCH-1:0]     r_play;
    logic [NCH-1:0]     r_pend;
    logic [AW-1:0]      r_ptr [NCH];
    logic [AW-1:0]      r_rem [NCH];
    logic signed [15:0] r_smp [NCH];
    logic               w_tick;
    logic [NCH-1:0]     w_edge;
    logic [NCH-1:0]     w_fetch;
    logic signed [20:0] w_prod [NCH];
    logic signed [18:0] w_sum;

    assign w_tick = (I_DIV != '0) && (r_div_cnt == I_DIV - DIVW'(1));
    // r_armed masks the first cycle after reset so a trigger held high through release is not an edge
    assign w_edge = I_TRIG & ~r_trig_q & {NCH{r_armed}};
    assign O_BUSY = r_play;

    always_comb begin
        w_sum   = '0;
        w_fetch = '0;
        for (int c = 0; c < NCH; c++) begin
            w_fetch[c] = r_phase && (r_slot == SW'(c)) && r_pend[c];
            w_prod[c]  = r_smp[c] * $signed({1'b0, I_VOL});
            w_sum      = w_sum + 19'($signed(O_SND[c*16 +: 16]));
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_div_cnt  <= '0;
            r_slot     <= '0;
            r_phase    <= 1'b0;
            r_armed    <= 1'b0;
            r_trig_q   <= '0;
            O_ROM_ADDR <= '0;
            O_SND      <= '0;
            O_MIX      <= '0;
        end else begin
            r_div_cnt <= (I_DIV == '0 || r_div_cnt >= I_DIV - DIVW'(1)) ? '0 : r_div_cnt + DIVW'(1);
            r_phase   <= ~r_phase;
            r_armed   <= 1'b1;
            r_trig_q  <= I_TRIG;
            if (r_phase)
                r_slot <= (r_slot == SW'(NCH - 1)) ? '0 : r_slot + SW'(1);
            else
                O_ROM_ADDR <= r_ptr[r_slot];
            for (int c = 0; c < NCH; c++)
                O_SND[c*16 +: 16] <= w_prod[c][19:4];
            O_MIX <= (w_sum > 19'sd32767) ? 16'h7FFF : (w_sum < -19'sd32768) ? 16'h8000 : w_sum[15:0];
        end
    end

    // Stop beats trigger; an accepted trigger beats a fetch in the same cycle (fetch cancelled).
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_play <= '0;
            r_pend <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_ptr[c] <= '0;
                r_rem[c] <= '0;
                r_smp[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (I_STOP[c]) begin
                    r_play[c] <= 1'b0;
                    r_pend[c] <= 1'b0;
                    r_smp[c]  <= '0;
                end else if (w_edge[c] && (r_play[c] ? I_RETRIG_EN[c] : (I_LEN[c*AW +: AW] != '0))) begin
                    r_play[c] <= 1'b1;
                    r_pend[c] <= 1'b0;
                    r_ptr[c]  <= I_START[c*AW +: AW];
                    r_rem[c]  <= I_LEN[c*AW +: AW];
                    if (!r_play[c])
                        r_smp[c] <= '0;
                end else if (r_play[c]) begin
                    r_pend[c] <= w_tick | (r_pend[c] & ~w_fetch[c]);
                    if (w_fetch[c]) begin
                        r_smp[c] <= I_ROM_DATA;
                        r_ptr[c] <= r_ptr[c] + AW'(1);
                        r_rem[c] <= r_rem[c] - AW'(1);
                        if (r_rem[c] == AW'(1)) begin
                            if (I_LOOP[c]) begin
                                r_ptr[c] <= I_START[c*AW +: AW];
                                r_rem[c] <= I_LEN[c*AW +: AW];
                            end else begin
                                r_play[c] <= 1'b0;
                                r_pend[c] <= 1'b0;
                            end
                        end
                    end
                end else begin
                    r_smp[c] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mario_sample_player_mc.sv
// tb_mario_sample_player_mc: directed scenarios plus randomized traffic, every cycle checked
// against a frame-arithmetic reference model of the sample player.
module tb_mario_sample_player_mc;
    localparam int NCH   = 3;
    localparam int AW    = 13;
    localparam int DIVW  = 12;
    localparam int AMASK = (1 << AW) - 1;

    logic              clk;
    logic              rst_n;
    logic [DIVW-1:0]   div;
    logic [3:0]        vol;
    logic [NCH-1:0]    trig, stop, retrig, loop_en;
    logic [NCH*AW-1:0] start_v, len_v;
    logic [AW-1:0]     rom_addr;
    logic [15:0]       rom_data;
    logic [NCH-1:0]    busy;
    logic [NCH*16-1:0] snd;
    logic [15:0]       mix;
    int                rom_mode;

    int n_cmp = 0;
    int n_bad = 0;

    bit m_play [NCH];
    bit m_pend [NCH];
    bit m_tprev [NCH];
    int m_ptr [NCH];
    int m_rem [NCH];
    int m_smp [NCH];
    int m_snd [NCH];
    int m_mix, m_addr, m_n;

    mario_sample_player_mc #(.NCH(NCH), .AW(AW), .DIVW(DIVW)) dut (
        .I_CLK(clk), .I_RSTn(rst_n), .I_DIV(div), .I_VOL(vol),
        .I_TRIG(trig), .I_STOP(stop), .I_RETRIG_EN(retrig), .I_LOOP(loop_en),
        .I_START(start_v), .I_LEN(len_v), .O_ROM_ADDR(rom_addr), .I_ROM_DATA(rom_data),
        .O_BUSY(busy), .O_SND(snd), .O_MIX(mix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_f(input logic [AW-1:0] a, input int mode);
        logic [31:0] t;
        t = a * 32'd40503;
        return (mode == 0) ? 16'(a) : (mode == 1) ? 16'h7FFF : (mode == 2) ? 16'h8000 : (t[15:0] ^ 16'h5A5A);
    endfunction

    always_comb rom_data = rom_f(rom_addr, rom_mode);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_play[c] = 0; m_pend[c] = 0; m_tprev[c] = 0;
            m_ptr[c] = 0; m_rem[c] = 0; m_smp[c] = 0; m_snd[c] = 0;
        end
        m_mix = 0; m_addr = 0; m_n = 0;
    endtask

    // Predicts the state after the coming clock edge from the inputs now applied.
    task automatic model_step();
        int slot, ph, s, st, ln;
        bit tick, e, fetch, np;
        logic signed [15:0] rd;
        slot = (m_n / 2) % NCH;
        ph   = m_n % 2;
        tick = (div == 0) ? 1'b0 : ((m_n % int'(div)) == int'(div) - 1);
        rd   = rom_f(m_addr[AW-1:0], rom_mode);
        s = 0;
        for (int c = 0; c < NCH; c++) s += m_snd[c];
        m_mix = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
        for (int c = 0; c < NCH; c++) m_snd[c] = (m_smp[c] * int'(vol)) >>> 4;
        if (ph == 0) m_addr = m_ptr[slot];
        for (int c = 0; c < NCH; c++) begin
            e     = trig[c] && !m_tprev[c] && m_n > 0;
            fetch = (ph == 1) && (slot == c) && m_pend[c];
            st    = int'(start_v[c*AW +: AW]);
            ln    = int'(len_v[c*AW +: AW]);
            if (stop[c]) begin
                m_play[c] = 0; m_pend[c] = 0; m_smp[c] = 0;
            end else if (e && (m_play[c] ? retrig[c] : (ln != 0))) begin
                if (!m_play[c]) m_smp[c] = 0;
                m_play[c] = 1; m_pend[c] = 0; m_ptr[c] = st; m_rem[c] = ln;
            end else if (m_play[c]) begin
                np = tick || (m_pend[c] && !fetch);
                if (fetch) begin
                    m_smp[c] = rd;
                    m_ptr[c] = (m_ptr[c] + 1) & AMASK;
                    m_rem[c] = (m_rem[c] - 1) & AMASK;
                    if (m_rem[c] == 0) begin
                        if (loop_en[c]) begin
                            m_ptr[c] = st; m_rem[c] = ln;
                        end else begin
                            m_play[c] = 0; np = 0;
                        end
                    end
                end
                m_pend[c] = np;
            end else begin
                m_smp[c] = 0;
            end
        end
        for (int c = 0; c < NCH; c++) m_tprev[c] = trig[c];
        m_n++;
    endtask

    task automatic compare_all();
        logic [NCH-1:0]    eb;
        logic [NCH*16-1:0] es;
        for (int c = 0; c < NCH; c++) begin
            eb[c] = m_play[c];
            es[c*16 +: 16] = m_snd[c][15:0];
        end
        chk("rom_addr", rom_addr, m_addr[AW-1:0]);
        chk("busy", busy, eb);
        chk("snd", snd, es);
        chk("mix", mix, m_mix[15:0]);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int k);
        repeat (k) cycle();
    endtask

    // True when the last edge loaded O_ROM_ADDR from the pointer of channel c.
    function automatic bit shown(input int c);
        return ((m_n - 1) % (2 * NCH)) == 2 * c;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        trig  = '0;
        stop  = '0;
        model_reset();
        @(negedge clk);
        chk("rst_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_snd", snd, 0);
        chk("rst_mix", mix, 0);
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        int seen0, seen1, other, low, idx;
        bit started, done;
        logic [7:0] mask;
        logic [DIVW-1:0] divs [5];
        divs[0] = 6; divs[1] = 7; divs[2] = 11; divs[3] = 25; divs[4] = 0;
        rst_n = 1'b0; div = '0; vol = '0; trig = '0; stop = '0; retrig = '0; loop_en = '0;
        start_v = '0; len_v = '0; rom_mode = 0;
        model_reset();

        // Single non-looping channel plays exactly its four words.
        div = 12'd1088; vol = 4'd15; rom_mode = 0;
        start_v[1*AW +: AW] = 13'h800; len_v[1*AW +: AW] = 13'd4;
        do_reset();
        trig[1] = 1'b1;
        mask = '0; started = 0; done = 0;
        for (int i = 0; i < 6000 && !done; i++) begin
            cycle();
            if (busy[1]) started = 1;
            if (started && !busy[1]) done = 1;
            if (shown(1) && busy[1] && rom_addr >= 13'h800 && rom_addr <= 13'h807) begin
                idx = int'(rom_addr) - 'h800;
                mask[idx] = 1'b1;
            end
        end
        chk("a_done", done, 1);
        chk("a_fetch_set", mask, 8'h0F);
        run(2);
        chk("a_busy_end", busy[1], 0);
        chk("a_snd_end", snd[16 +: 16], 0);

        // Looping channel alternates 0,1 until stopped.
        div = 12'd6; loop_en[0] = 1'b1; start_v[0 +: AW] = 13'd0; len_v[0 +: AW] = 13'd2;
        do_reset();
        trig[0] = 1'b1;
        cycle();
        seen0 = 0; seen1 = 0; other = 0; low = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (!busy[0]) low++;
            if (shown(0)) begin
                if (rom_addr == 0) seen0++;
                else if (rom_addr == 1) seen1++;
                else other++;
            end
        end
        chk("b_other_addr", other, 0);
        chk("b_both_seen", (seen0 > 0) && (seen1 > 0), 1);
        chk("b_busy_held", low, 0);
        stop[0] = 1'b1;
        cycle();
        stop[0] = 1'b0;
        chk("b_stop_idle", busy[0], 0);
        cycle();
        chk("b_stop_snd", snd[0 +: 16], 0);

        // Retrigger ignored while disabled, honoured when enabled.
        loop_en = '0; rom_mode = 3;
        start_v[2*AW +: AW] = 13'h100; len_v[2*AW +: AW] = 13'd50; retrig[2] = 1'b0;
        do_reset();
        trig[2] = 1'b1;
        run(60);
        trig[2] = 1'b0;
        cycle();
        trig[2] = 1'b1;
        cycle();
        for (int i = 0; i < 2 * NCH; i++) begin
            cycle();
            if (shown(2)) break;
        end
        chk("c_ignored", (rom_addr > 13'h100) && busy[2], 1);
        retrig[2] = 1'b1;
        trig[2] = 1'b0;
        cycle();
        trig[2] = 1'b1;
        cycle();
        for (int i = 0; i < 2 * NCH; i++) begin
            cycle();
            if (shown(2)) break;
        end
        chk("c_restart", rom_addr, 13'h100);

        // Full-scale data on every channel saturates the mix.
        rom_mode = 1; vol = 4'd15; retrig = '0; loop_en = '1;
        for (int c = 0; c < NCH; c++) begin
            start_v[c*AW +: AW] = '0; len_v[c*AW +: AW] = 13'd4;
        end
        do_reset();
        trig = '1;
        run(60);
        chk("d_snd_pos", snd, {NCH{16'h77FF}});
        chk("d_mix_pos", mix, 16'h7FFF);
        rom_mode = 2;
        run(60);
        chk("d_snd_neg", snd, {NCH{16'h8800}});
        chk("d_mix_neg", mix, 16'h8000);

        // Stop wins over a simultaneous edge; zero length ignored.
        loop_en = '0; rom_mode = 3;
        do_reset();
        stop[1] = 1'b1; trig[1] = 1'b1;
        cycle();
        stop[1] = 1'b0;
        run(20);
        chk("e_stop_edge", busy[1], 0);
        trig[1] = 1'b0; len_v[1*AW +: AW] = '0;
        cycle();
        trig[1] = 1'b1;
        run(20);
        chk("e_len_zero", busy[1], 0);

        // Asynchronous reset mid-playback, trigger held high through release.
        rom_mode = 0; loop_en[0] = 1'b1; start_v[0 +: AW] = 13'd5; len_v[0 +: AW] = 13'd3;
        do_reset();
        trig[0] = 1'b1;
        run(40);
        chk("f_playing", busy[0], 1);
        model_step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("f_async_addr", rom_addr, 0);
        chk("f_async_busy", busy, 0);
        chk("f_async_snd", snd, 0);
        chk("f_async_mix", mix, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(50);
        chk("f_no_play", busy, 0);

        // Randomized traffic.
        rom_mode = 3;
        for (int seg = 0; seg < 6; seg++) begin
            div = divs[$urandom_range(0, 4)];
            vol = 4'($urandom);
            for (int c = 0; c < NCH; c++) begin
                start_v[c*AW +: AW] = AW'($urandom);
                len_v[c*AW +: AW]   = AW'($urandom_range(0, 5));
            end
            retrig = NCH'($urandom); loop_en = NCH'($urandom);
            do_reset();
            for (int i = 0; i < 600; i++) begin
                for (int c = 0; c < NCH; c++) begin
                    if ($urandom_range(0, 19) == 0) trig[c] = ~trig[c];
                    stop[c] = ($urandom_range(0, 79) == 0);
                end
                if ($urandom_range(0, 49) == 0) begin
                    idx = $urandom_range(0, NCH - 1);
                    retrig[idx] = 1'($urandom);
                    loop_en[idx] = 1'($urandom);
                    start_v[idx*AW +: AW] = AW'($urandom);
                    len_v[idx*AW +: AW] = AW'($urandom_range(0, 5));
                end
                if ($urandom_range(0, 99) == 0) vol = 4'($urandom);
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
